// File: rtl/imem_boot_loader.sv
// Framed byte-stream program loader: assembles little-endian words into instruction
// memory and holds the CPU in reset until the image checksum verifies.
module imem_boot_loader #(
  parameter int ADDR_W      = 10,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_reset,
  output logic              done,
  output logic              error
);

  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_W;

  typedef enum logic [2:0] {HDR0, HDR1, DATA, CSUM, DONE, ERR} state_t;

  state_t            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic [1:0]        byte_idx_q, byte_idx_d;
  logic [31:0]       word_q, word_d;
  logic [7:0]        csum_q, csum_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              rx_ready_q, cpu_reset_q, done_q, error_q;

  logic              accept;
  logic [31:0]       n_hdr;
  logic [ADDR_W:0]   words_inc;

  assign accept    = rx_valid && rx_ready_q;
  assign n_hdr     = {16'd0, rx_data, cnt_q[7:0]};
  assign words_inc = words_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    words_d    = words_q;
    byte_idx_d = byte_idx_q;
    word_d     = word_q;
    csum_d     = csum_q;
    timer_d    = timer_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if (accept) begin
      timer_d = '0;
      case (state_q)
        HDR0: begin
          cnt_d[7:0] = rx_data;
          state_d    = HDR1;
        end
        HDR1: begin
          cnt_d[15:8] = rx_data;
          if (n_hdr > MAX_WORDS)  state_d = ERR;
          else if (n_hdr == 32'd0) state_d = CSUM;
          else                     state_d = DATA;
        end
        DATA: begin
          csum_d     = csum_q ^ rx_data;
          word_d     = {rx_data, word_q[31:8]};
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = words_q[ADDR_W-1:0];
            wdata_d = word_d;
            words_d = words_inc;
            if (32'(words_inc) == {16'd0, cnt_q}) state_d = CSUM;
          end
        end
        CSUM: state_d = (rx_data == csum_q) ? DONE : ERR;
        default: ;
      endcase
    end else if (state_q == HDR1 || state_q == DATA || state_q == CSUM) begin
      // Timer holds the count of idle edges since the last accepted byte.
      timer_d = timer_q + 1'b1;
      if (timer_q == TMR_LAST) state_d = ERR;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= HDR0;
      cnt_q       <= '0;
      words_q     <= '0;
      byte_idx_q  <= '0;
      word_q      <= '0;
      csum_q      <= '0;
      timer_q     <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rx_ready_q  <= 1'b1;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      words_q     <= words_d;
      byte_idx_q  <= byte_idx_d;
      word_q      <= word_d;
      csum_q      <= csum_d;
      timer_q     <= timer_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rx_ready_q  <= (state_d != DONE) && (state_d != ERR);
      cpu_reset_q <= (state_d != DONE);
      done_q      <= (state_d == DONE);
      error_q     <= (state_d == ERR);
    end
  end

  assign rx_ready   = rx_ready_q;
  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_reset  = cpu_reset_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: good/bad/empty/oversize images, timeout and mid-frame reset.
module tb_imem_boot_loader;
  localparam int ADDR_W = 10;
  localparam int TOUT   = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_ready, imem_we, cpu_reset, done, error;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  int tests = 0;
  int failed = 0;
  int wr_count = 0;
  logic [31:0] wr_addr [8];
  logic [31:0] wr_data [8];
  logic [7:0]  img [11];

  imem_boot_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TOUT)) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_reset(cpu_reset), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (imem_we) begin
      if (wr_count < 8) begin
        wr_addr[wr_count] = 32'(imem_addr);
        wr_data[wr_count] = imem_wdata;
      end
      $display("[TB] write addr=%0d data=%08h", imem_addr, imem_wdata);
      wr_count = wr_count + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests = tests + 1;
    assert (obs === exp) else begin
      failed = failed + 1;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rx_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    wr_count = 0;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rx_ready"},  32'(rx_ready),   32'd1);
    check({tag, "_imem_we"},   32'(imem_we),    32'd0);
    check({tag, "_imem_addr"}, 32'(imem_addr),  32'd0);
    check({tag, "_wdata"},     imem_wdata,      32'd0);
    check({tag, "_cpu_reset"}, 32'(cpu_reset),  32'd1);
    check({tag, "_done"},      32'(done),       32'd0);
    check({tag, "_error"},     32'(error),      32'd0);
  endtask

  task automatic check_two_writes(input string tag);
    check({tag, "_wr_count"}, 32'(wr_count), 32'd2);
    check({tag, "_addr0"},    wr_addr[0],    32'd0);
    check({tag, "_data0"},    wr_data[0],    32'h0000_0013);
    check({tag, "_addr1"},    wr_addr[1],    32'd1);
    check({tag, "_data1"},    wr_data[1],    32'h0050_0093);
  endtask

  initial begin
    img = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'hD0};

    // Reset state
    do_reset();
    check_reset_vals("rst");

    // Good two-word image, continuous bytes
    for (int i = 0; i < 11; i++) send_byte(img[i]);
    idle(1);
    check_two_writes("good");
    check("good_done",      32'(done),      32'd1);
    check("good_cpu_reset", 32'(cpu_reset), 32'd0);
    check("good_rx_ready",  32'(rx_ready),  32'd0);
    check("good_error",     32'(error),     32'd0);

    // Bad checksum
    do_reset();
    for (int i = 0; i < 10; i++) send_byte(img[i]);
    send_byte(8'hD1);
    idle(1);
    check_two_writes("badck");
    check("badck_error", 32'(error), 32'd1);
    check("badck_done",  32'(done),  32'd0);
    idle(100);
    check("badck_cpu_reset_held", 32'(cpu_reset), 32'd1);

    // Empty image
    do_reset();
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    idle(1);
    check("empty_done",     32'(done),     32'd1);
    check("empty_wr_count", 32'(wr_count), 32'd0);

    // Oversize header N=1025
    do_reset();
    send_byte(8'h01);
    send_byte(8'h04);
    idle(1);
    check("big_error",    32'(error),    32'd1);
    check("big_rx_ready", 32'(rx_ready), 32'd0);
    check("big_wr_count", 32'(wr_count), 32'd0);

    // Timeout: error exactly TOUT edges after the last accept
    do_reset();
    for (int i = 0; i < 5; i++) send_byte(img[i]);
    idle(1);
    idle(TOUT - 1);
    check("tmo_before", 32'(error), 32'd0);
    idle(1);
    check("tmo_at",        32'(error),     32'd1);
    check("tmo_cpu_reset", 32'(cpu_reset), 32'd1);

    // Gaps of TOUT-1 idle cycles must not time out
    do_reset();
    for (int i = 0; i < 11; i++) begin
      send_byte(img[i]);
      idle(TOUT - 1);
    end
    check_two_writes("gap");
    check("gap_done",  32'(done),  32'd1);
    check("gap_error", 32'(error), 32'd0);

    // Reset mid-frame, then reload with random gaps
    do_reset();
    for (int i = 0; i < 6; i++) send_byte(img[i]);
    do_reset();
    check_reset_vals("midrst");
    for (int i = 0; i < 11; i++) begin
      send_byte(img[i]);
      idle(int'($urandom_range(0, TOUT - 1)));
    end
    idle(1);
    check_two_writes("reload");
    check("reload_done",      32'(done),      32'd1);
    check("reload_cpu_reset", 32'(cpu_reset), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
